instr_prefetch_queue: RTL and testbench
=======================================

// Module: instr_prefetch_queue
// PURPOSE
//  Fetch front end feeding the decode stage. Issues sequential instruction reads to main memory
//  and buffers returned words with their PCs in an in-order queue. Presents one {pc, instr} per
//  handshake to ID. A taken branch from EX redirects fetch and flushes all wrong-path state.
// PARAMETERS
//  XLEN             32  address/PC width
//  DEPTH            4   queue entries; power of 2, >=2
//  MAX_OUTSTANDING  2   max memory reads in flight, >=1
//  RESET_PC         0   first fetch address after reset
// PORTS
//  clk             in   1     core clock
//  rst             in   1     asynchronous, active-low reset
//  redirect_en     in   1     taken branch; load redirect_addr this cycle
//  redirect_addr   in   XLEN  branch target; bits[1:0] forced to 0
//  mem_req_valid   out  1     read request valid
//  mem_req_ready   in   1     memory accepts request
//  mem_req_addr    out  XLEN  read address
//  mem_resp_valid  in   1     read data returned; in order; >=1 cycle after accept
//  mem_resp_data   in   32    instruction word
//  id_valid        out  1     id_instr/id_pc valid
//  id_ready        in   1     decode consumes (low = halt)
//  id_instr        out  32    instruction; NOP_INSTR when id_valid=0
//  id_pc           out  XLEN  PC of id_instr
// BEHAVIOUR
//  Reset (rst=0, async): fetch_pc=RESET_PC, resp_pc=RESET_PC, queue empty, outstanding=0, drop_cnt=0.
//   Outputs: mem_req_valid=0, mem_req_addr=RESET_PC, id_valid=0, id_instr=NOP_INSTR, id_pc=0.
//  Issue: mem_req_valid = !redirect_en && outstanding<MAX_OUTSTANDING && count+outstanding<DEPTH.
//   mem_req_addr=fetch_pc. Accept (valid&ready): fetch_pc+=4 mod 2^XLEN, outstanding++.
//   Address is held stable while valid && !ready, unless a redirect occurs.
//  Response: every mem_resp_valid decrements outstanding.
//   If drop_cnt>0: discard the word, drop_cnt--.
//   Otherwise enqueue {resp_pc, data}, resp_pc+=4.
//   Queue never overflows because issue is gated by reserved slots.
//  mem_resp_valid with outstanding=0 is a protocol error: ignore it; an SVA assertion fires.
//  Dequeue on id_valid && id_ready. Simultaneous enqueue and dequeue is legal at any count.
//  Redirect cycle T: mem_req_valid=0; id_valid forced 0 (no handshake); any response at T is discarded.
//   At T+1: queue empty; fetch_pc=resp_pc=redirect_addr; drop_cnt=outstanding-resp_valid(T).
//   The first request to redirect_addr is issued at T+1. Earliest id_valid is the cycle after its response.
//  Back-to-back redirects: the last one wins; drop_cnt recomputes from current outstanding.
//  Reset mid-operation clears everything immediately. Responses after reset are not expected.
// CONFIGURATION
//  PFQ_BYPASS_EN defined: queue empty, response not dropped, no redirect ->
//   the response drives id_* combinationally in the same cycle.
//   If id_ready=1 it is consumed and not enqueued; otherwise it is enqueued normally.
//  Undefined: every response is enqueued; id_valid rises at the earliest the following cycle.
// STRUCTURE
//  core_pkg: XLEN, NOP_INSTR=32'h0000_0013, RESET_PC default, typedef pfq_entry_t {pc, instr}.
//  Sub-module pfq_fifo: generic sync FIFO of pfq_entry_t, DEPTH entries, same clk/rst,
//   flush input, count output. Counters and the drop logic stay in the top.
// TESTING
//  1. Reset, mem ready, 1-cycle latency, id_ready=1 -> id_pc 0,4,8,... one per cycle;
//     id_instr matches memory.
//  2. id_ready=0 for 10 cycles -> count saturates at DEPTH; mem_req_valid=0;
//     no loss; order kept on release.
//  3. redirect_en to 0x100 with 2 outstanding -> both late responses dropped;
//     next id_pc=0x100; no wrong-path id_valid.
//  4. Redirect in the same cycle as a response and id_ready=1 ->
//     response discarded, no handshake, drop_cnt=outstanding-1.
//  5. mem_req_ready low 5 cycles -> mem_req_addr stable; single accept; no duplicate fetch.
//  6. fetch_pc=0xFFFF_FFFC -> next request addr 0x0000_0000.
//     PFQ_BYPASS_EN on empty queue -> id_valid in the response cycle.

Source files
------------

// File: rtl/core_pkg.sv
// Shared fetch-side types and constants.
// Exports XLEN, NOP_INSTR, DEFAULT_RESET_PC, pfq_entry_t.
package core_pkg;

    localparam int XLEN = 32;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    localparam logic [XLEN-1:0] DEFAULT_RESET_PC = '0;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [31:0]     instr;
    } pfq_entry_t;

endpackage

// File: rtl/pfq_fifo.sv
// Sync FIFO of pfq_entry_t; clk, rst (async low), flush,
// push/push_data, pop/pop_data, count, empty.
module pfq_fifo
    import core_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          push,
    input  pfq_entry_t    push_data,
    input  logic          pop,
    output pfq_entry_t    pop_data,
    output logic [CW-1:0] count,
    output logic          empty
);

    localparam int AW = $clog2(DEPTH);

    pfq_entry_t    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          full;
    logic          do_push;
    logic          do_pop;

    assign empty    = (count == '0);
    assign full     = (count == CW'(DEPTH));
    // a push into a full queue is fine when the head leaves this cycle
    assign do_push  = push && (!full || pop);
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/instr_prefetch_queue.sv
// Fetch front end: sequential reads to memory, in-order queue to ID,
// redirect flush with late-response drop. Ports: clk, rst (async low),
// redirect_*, mem_req_*, mem_resp_*, id_*. PFQ_BYPASS_EN: empty-queue
// response forwarded to ID in the same cycle.
module instr_prefetch_queue
    import core_pkg::*;
#(
    parameter int              DEPTH           = 4,
    parameter int              MAX_OUTSTANDING = 2,
    parameter logic [XLEN-1:0] RESET_PC        = DEFAULT_RESET_PC
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            redirect_en,
    input  logic [XLEN-1:0] redirect_addr,
    output logic            mem_req_valid,
    input  logic            mem_req_ready,
    output logic [XLEN-1:0] mem_req_addr,
    input  logic            mem_resp_valid,
    input  logic [31:0]     mem_resp_data,
    output logic            id_valid,
    input  logic            id_ready,
    output logic [31:0]     id_instr,
    output logic [XLEN-1:0] id_pc
);

    localparam int OW = $clog2(MAX_OUTSTANDING + 1);
    localparam int CW = $clog2(DEPTH + 1);

    logic [XLEN-1:0] fetch_pc;
    logic [XLEN-1:0] resp_pc;
    logic [XLEN-1:0] target;
    logic [OW-1:0]   outstanding;
    logic [OW-1:0]   drop_cnt;
    logic [CW-1:0]   count;
    logic            empty;
    pfq_entry_t      head;
    pfq_entry_t      push_entry;
    logic            accept;
    logic            resp_ok;
    logic            keep;
    logic            byp;
    logic            push;
    logic            pop;

    assign target = redirect_addr & ~XLEN'(3);

    // slots are reserved at issue time, so the queue cannot overflow
    assign mem_req_valid = rst && !redirect_en
        && (32'(outstanding) < 32'(MAX_OUTSTANDING))
        && ((32'(count) + 32'(outstanding)) < 32'(DEPTH));
    assign mem_req_addr = fetch_pc;
    assign accept       = mem_req_valid && mem_req_ready;

    // stray responses with nothing in flight are ignored
    assign resp_ok = mem_resp_valid && (outstanding != '0);
    assign keep    = resp_ok && !redirect_en && (drop_cnt == '0);

`ifdef PFQ_BYPASS_EN
    assign byp = keep && empty;
`else
    assign byp = 1'b0;
`endif

    assign id_valid = !redirect_en && (!empty || byp);
    assign id_pc    = !id_valid ? '0
                    : (empty ? resp_pc : head.pc);
    assign id_instr = !id_valid ? NOP_INSTR
                    : (empty ? mem_resp_data : head.instr);

    assign push       = keep && !(byp && id_ready);
    assign pop        = id_valid && id_ready && !empty;
    assign push_entry = '{pc: resp_pc, instr: mem_resp_data};

    pfq_fifo #(
        .DEPTH (DEPTH),
        .CW    (CW)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (redirect_en),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .pop_data  (head),
        .count     (count),
        .empty     (empty)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc    <= RESET_PC;
            resp_pc     <= RESET_PC;
            outstanding <= '0;
            drop_cnt    <= '0;
        end else begin
            outstanding <= outstanding + OW'(accept) - OW'(resp_ok);
            if (redirect_en) begin
                fetch_pc <= target;
                resp_pc  <= target;
                // everything still in flight after this cycle is wrong-path
                drop_cnt <= outstanding - OW'(resp_ok);
            end else begin
                if (accept) begin
                    fetch_pc <= fetch_pc + XLEN'(4);
                end
                if (keep) begin
                    resp_pc <= resp_pc + XLEN'(4);
                end
                if (resp_ok && (drop_cnt != '0)) begin
                    drop_cnt <= drop_cnt - 1'b1;
                end
            end
        end
    end

    a_resp_in_flight : assert property (
        @(posedge clk) disable iff (!rst)
        mem_resp_valid |-> (outstanding != '0)
    );

endmodule

// File: tb/tb_instr_prefetch_queue.sv
// Randomized bench for instr_prefetch_queue against a queue-based
// reference model; honours PFQ_BYPASS_EN when defined.
module tb_instr_prefetch_queue;
    import core_pkg::*;

    localparam int DEPTH = 4;
    localparam int MAXO  = 2;
`ifdef PFQ_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } ent_t;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } fl_t;

    logic        clk;
    logic        rst;
    logic        redirect_en;
    logic [31:0] redirect_addr;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [31:0] mem_req_addr;
    logic        mem_resp_valid;
    logic [31:0] mem_resp_data;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_instr;
    logic [31:0] id_pc;

    instr_prefetch_queue #(
        .DEPTH           (DEPTH),
        .MAX_OUTSTANDING (MAXO)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .redirect_en    (redirect_en),
        .redirect_addr  (redirect_addr),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_req_addr   (mem_req_addr),
        .mem_resp_valid (mem_resp_valid),
        .mem_resp_data  (mem_resp_data),
        .id_valid       (id_valid),
        .id_ready       (id_ready),
        .id_instr       (id_instr),
        .id_pc          (id_pc)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] act,
                         input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] memfn(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h1357_9bdf;
    endfunction

    // reference model state
    logic [31:0] m_fetch;
    logic [31:0] m_rpc;
    int          m_drop;
    ent_t        q[$];
    fl_t         fl[$];
    int          cyc;

    // stimulus knobs
    int          p_rdy;
    int          p_idr;
    int          p_resp;
    int          p_redir;
    int          lat_max;
    bit          force_redir2;
    bit          force_once;
    logic [31:0] force_target;

    task automatic model_reset();
        q.delete();
        fl.delete();
        m_fetch = 32'h0;
        m_rpc   = 32'h0;
        m_drop  = 0;
    endtask

    task automatic check_reset_outputs();
        check("rst_req_valid", mem_req_valid, 1'b0);
        check("rst_req_addr", mem_req_addr, 32'h0);
        check("rst_id_valid", id_valid, 1'b0);
        check("rst_id_instr", id_instr, NOP_INSTR);
        check("rst_id_pc", id_pc, 32'h0);
    endtask

    task automatic run(input int n);
        int   pend;
        bit   exp_req;
        bit   exp_idv;
        bit   has_vis;
        bit   consumed;
        ent_t vis;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            mem_req_ready  = ($urandom_range(99) < p_rdy);
            id_ready       = ($urandom_range(99) < p_idr);
            mem_resp_valid = 1'b0;
            mem_resp_data  = $urandom;
            if (fl.size() > 0 && fl[0].due <= cyc
                && $urandom_range(99) < p_resp) begin
                mem_resp_valid = 1'b1;
                mem_resp_data  = memfn(fl[0].addr);
            end
            redirect_en   = ($urandom_range(999) < p_redir);
            redirect_addr = $urandom;
            if (force_redir2 && fl.size() == 2) begin
                redirect_en = 1'b1;
            end
            if (force_once) begin
                redirect_en   = 1'b1;
                redirect_addr = force_target;
                force_once    = 1'b0;
            end
            #2;
            pend    = fl.size();
            exp_req = !redirect_en && pend < MAXO
                      && (q.size() + pend) < DEPTH;
            check("mem_req_valid", mem_req_valid, exp_req);
            check("mem_req_addr", mem_req_addr, m_fetch);
            has_vis = 1'b0;
            vis     = '{32'h0, 32'h0};
            if (q.size() > 0) begin
                has_vis = 1'b1;
                vis     = q[0];
            end else if (BYP && mem_resp_valid && m_drop == 0
                         && !redirect_en) begin
                has_vis = 1'b1;
                vis     = '{m_rpc, mem_resp_data};
            end
            exp_idv = !redirect_en && has_vis;
            check("id_valid", id_valid, exp_idv);
            if (exp_idv) begin
                check("id_pc", id_pc, vis.pc);
                check("id_instr", id_instr, memfn(vis.pc));
            end else begin
                check("id_instr_nop", id_instr, NOP_INSTR);
            end
            if (mem_resp_valid) begin
                void'(fl.pop_front());
            end
            if (mem_req_valid && mem_req_ready) begin
                fl.push_back('{mem_req_addr,
                               cyc + int'($urandom_range(lat_max, 1))});
            end
            if (redirect_en) begin
                q.delete();
                m_fetch = redirect_addr & 32'hFFFF_FFFC;
                m_rpc   = m_fetch;
                m_drop  = pend - (mem_resp_valid ? 1 : 0);
            end else begin
                consumed = 1'b0;
                if (exp_idv && id_ready) begin
                    if (q.size() > 0) begin
                        void'(q.pop_front());
                    end else begin
                        consumed = 1'b1;
                    end
                end
                if (mem_resp_valid) begin
                    if (m_drop > 0) begin
                        m_drop--;
                    end else begin
                        if (!consumed) begin
                            q.push_back('{m_rpc, mem_resp_data});
                        end
                        m_rpc = m_rpc + 32'd4;
                    end
                end
                if (exp_req && mem_req_ready) begin
                    m_fetch = m_fetch + 32'd4;
                end
            end
            cyc++;
        end
    endtask

    task automatic set_knobs(input int rdy, input int idr, input int resp,
                             input int lat, input int redir);
        p_rdy   = rdy;
        p_idr   = idr;
        p_resp  = resp;
        lat_max = lat;
        p_redir = redir;
    endtask

    initial begin
        rst            = 1'b0;
        redirect_en    = 1'b0;
        redirect_addr  = '0;
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;
        mem_resp_data  = '0;
        id_ready       = 1'b0;
        force_redir2   = 1'b0;
        force_once     = 1'b0;
        force_target   = '0;
        cyc            = 0;
        set_knobs(100, 100, 100, 1, 0);
        model_reset();
        #12;
        check_reset_outputs();
        @(negedge clk);
        rst = 1'b1;

        // streaming with single-cycle memory
        run(20);
        // decode stall, then release
        set_knobs(100, 0, 100, 1, 0);
        run(10);
        set_knobs(100, 100, 100, 1, 0);
        run(10);
        // redirects while two reads are in flight
        set_knobs(100, 100, 100, 3, 0);
        force_redir2 = 1'b1;
        run(8);
        force_redir2 = 1'b0;
        run(20);
        // memory back-pressure
        set_knobs(0, 100, 100, 1, 0);
        run(5);
        set_knobs(100, 100, 100, 1, 0);
        run(5);
        // address wrap at top of memory
        force_target = 32'hFFFF_FFF6;
        force_once   = 1'b1;
        run(12);
        // mixed random traffic
        set_knobs(70, 70, 70, 3, 50);
        run(1500);
        set_knobs(50, 40, 80, 4, 120);
        run(800);

        // reset in the middle of traffic
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        check_reset_outputs();
        mem_resp_valid = 1'b0;
        redirect_en    = 1'b0;
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        set_knobs(80, 80, 90, 2, 30);
        run(300);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
